// File: rtl/whack_mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package whack_mole_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSpawnWait,
    StMoleUp,
    StDone
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 for a left-shifting Fibonacci register: taps on bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned DEFAULT_ROUND_SECS = 20;
  localparam int unsigned SECS_W             = 5;

  function automatic logic [7:0] lfsr_next(logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/whack_mole_round_ctrl_if.sv
// Button inputs and display outputs of the round controller, bundled for the top-level port.
interface whack_mole_round_ctrl_if #(
  parameter int unsigned NUM_MOLES = 4,
  parameter int unsigned SCORE_W   = 8
);

  logic                 start;
  logic [NUM_MOLES-1:0] btn;
  logic [NUM_MOLES-1:0] mole_leds;
  logic [SCORE_W-1:0]   score;
  logic [4:0]           secs_left;
  logic                 playing;
  logic                 game_over;

  // Button/debounce side drives inputs and observes the display outputs.
  modport master (
    output start,
    output btn,
    input  mole_leds,
    input  score,
    input  secs_left,
    input  playing,
    input  game_over
  );

  modport slave (
    input  start,
    input  btn,
    output mole_leds,
    output score,
    output secs_left,
    output playing,
    output game_over
  );

endinterface

// File: rtl/whack_mole_round_ctrl_round_timer.sv
// Round countdown: prescaler of TICK_CYCLES per second and a seconds down-counter with an
// expire pulse on the cycle the count wraps from 1 to 0.
module whack_mole_round_ctrl_round_timer
  import whack_mole_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned ROUND_SECS  = DEFAULT_ROUND_SECS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              run_i,
  output logic [SECS_W-1:0] secs_left_o,
  output logic              expire_o
);

  localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
  localparam logic [SECS_W-1:0] SECS_INIT = SECS_W'(ROUND_SECS);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [SECS_W-1:0] secs_q, secs_d;
  logic              wrap;

  assign wrap     = run_i && (presc_q == PRE_LAST);
  assign expire_o = wrap && (secs_q == SECS_W'(1));

  always_comb begin
    presc_d = presc_q;
    secs_d  = secs_q;
    if (load_i) begin
      presc_d = '0;
      secs_d  = SECS_INIT;
    end else if (run_i) begin
      if (wrap) begin
        presc_d = '0;
        if (secs_q != '0) begin
          secs_d = secs_q - SECS_W'(1);
        end
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      secs_q  <= SECS_INIT;
    end else begin
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

  assign secs_left_o = secs_q;

endmodule

// File: rtl/whack_mole_round_ctrl.sv
// Whack-a-mole round controller: sequences moles from an LFSR, scores fresh single-button hits
// on the lit mole, and ends the round when the seconds countdown expires.
module whack_mole_round_ctrl
  import whack_mole_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned ROUND_SECS  = DEFAULT_ROUND_SECS,
  parameter int unsigned NUM_MOLES   = 4,
  parameter int unsigned MOLE_CYCLES = 75_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000,
  parameter int unsigned SCORE_W     = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  whack_mole_round_ctrl_if.slave bus
);

  localparam int unsigned TICK_CYCLES = CLK_HZ;
  localparam int unsigned LIT_W       = $clog2(NUM_MOLES);
  localparam int unsigned CNT_MAX     = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOLE_RELOAD = CNT_W'(MOLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [7:0]           lfsr_q;
  logic                 start_q, start_rise_q;
  logic [NUM_MOLES-1:0] btn_q, btn_rise_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LIT_W-1:0]     lit_q, lit_d;
  logic [SCORE_W-1:0]   score_q, score_d;

  logic                 timer_load;
  logic                 timer_run;
  logic                 timer_expire;
  logic [SECS_W-1:0]    secs_left;
  logic [NUM_MOLES-1:0] lit_onehot;
  logic                 hit;

  // Edge detectors are registered so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q      <= 1'b0;
      start_rise_q <= 1'b0;
      btn_q        <= '0;
      btn_rise_q   <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      start_q      <= bus.start;
      start_rise_q <= bus.start & ~start_q;
      btn_q        <= bus.btn;
      btn_rise_q   <= bus.btn & ~btn_q;
      lfsr_q       <= lfsr_next(lfsr_q);
    end
  end

  assign lit_onehot = NUM_MOLES'(1) << lit_q;
  // Any extra rising button alongside the lit one disqualifies the press.
  assign hit        = (btn_rise_q == lit_onehot);
  assign timer_run  = (state_q == StSpawnWait) || (state_q == StMoleUp);

  whack_mole_round_ctrl_round_timer #(
    .TICK_CYCLES(TICK_CYCLES),
    .ROUND_SECS (ROUND_SECS)
  ) u_round_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .run_i      (timer_run),
    .secs_left_o(secs_left),
    .expire_o   (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lit_d      = lit_q;
    score_d    = score_q;
    timer_load = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_rise_q) begin
          score_d    = '0;
          cnt_d      = GAP_RELOAD;
          timer_load = 1'b1;
          state_d    = StSpawnWait;
        end
      end
      StSpawnWait: begin
        if (cnt_q == '0) begin
          lit_d   = lfsr_q[LIT_W-1:0];
          cnt_d   = MOLE_RELOAD;
          state_d = StMoleUp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StMoleUp: begin
        if (hit) begin
          if (score_q != '1) begin
            score_d = score_q + SCORE_W'(1);
          end
          cnt_d   = GAP_RELOAD;
          state_d = StSpawnWait;
        end else if (cnt_q == '0) begin
          cnt_d   = GAP_RELOAD;
          state_d = StSpawnWait;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // The final tick overrides spawn/timeout moves, but a same-cycle hit is still scored.
    if (timer_expire) begin
      state_d = StDone;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lit_q   <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lit_q   <= lit_d;
      score_q <= score_d;
    end
  end

  assign bus.mole_leds = (state_q == StMoleUp) ? lit_onehot : '0;
  assign bus.score     = score_q;
  assign bus.secs_left = secs_left;
  assign bus.playing   = timer_run;
  assign bus.game_over = (state_q == StDone);

endmodule

// File: tb/tb_whack_mole_round_ctrl.sv
// Randomized bench for whack_mole_round_ctrl against a deadline-based round model.
module tb_whack_mole_round_ctrl;

  localparam int TICK  = 10;
  localparam int ROUND = 3;
  localparam int MOLE  = 6;
  localparam int GAP   = 2;
  localparam int NM    = 4;
  localparam int SW    = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  whack_mole_round_ctrl_if #(.NUM_MOLES(NM), .SCORE_W(SW)) bus ();

  whack_mole_round_ctrl #(
    .CLK_HZ     (TICK),
    .ROUND_SECS (ROUND),
    .NUM_MOLES  (NM),
    .MOLE_CYCLES(MOLE),
    .GAP_CYCLES (GAP),
    .SCORE_W    (SW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 waiting for mole, 2 mole up, 3 done. Phases end at absolute cycle numbers.
  int         m_mode, m_cyc, m_rs, m_end, m_score, m_lit;
  logic [7:0] m_lfsr;
  logic       s_h1, s_h2, srise;
  logic [3:0] b_h1, b_h2, brise;
  bit         was_playing;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_cyc = 0; m_rs = 0; m_end = 0; m_score = 0; m_lit = 0;
      m_lfsr = 8'hA5;
      s_h1 = 1'b0; s_h2 = 1'b0; b_h1 = '0; b_h2 = '0;
    end else begin
      m_cyc++;
      srise = s_h1 & ~s_h2;
      brise = b_h1 & ~b_h2;
      was_playing = (m_mode == 1) || (m_mode == 2);
      case (m_mode)
        0, 3: if (srise) begin
          m_mode = 1; m_rs = m_cyc; m_score = 0; m_end = m_cyc + GAP;
        end
        1: if (m_cyc == m_end) begin
          m_mode = 2; m_lit = m_lfsr % NM; m_end = m_cyc + MOLE;
        end
        2: if (brise == 4'(1 << m_lit)) begin
          if (m_score < (1 << SW) - 1) m_score++;
          m_mode = 1; m_end = m_cyc + GAP;
        end else if (m_cyc == m_end) begin
          m_mode = 1; m_end = m_cyc + GAP;
        end
        default: ;
      endcase
      if (was_playing && (m_cyc - m_rs == ROUND * TICK)) m_mode = 3;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      s_h2 = s_h1; s_h1 = bus.start;
      b_h2 = b_h1; b_h1 = bus.btn;
    end
  end

  function automatic int exp_leds();
    return (m_mode == 2) ? (1 << m_lit) : 0;
  endfunction

  function automatic int exp_secs();
    if (m_mode == 1 || m_mode == 2) return ROUND - (m_cyc - m_rs) / TICK;
    return (m_mode == 3) ? 0 : ROUND;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      check("cyc_leds", bus.mole_leds, exp_leds());
      check("cyc_score", bus.score, m_score);
      check("cyc_secs", bus.secs_left, exp_secs());
      check("cyc_playing", bus.playing, (m_mode == 1 || m_mode == 2) ? 1 : 0);
      check("cyc_game_over", bus.game_over, (m_mode == 3) ? 1 : 0);
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_mode(input int mode, input int max_cyc);
    int n = 0;
    while (m_mode != mode && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_mode", m_mode, mode);
  endtask

  task automatic play_random(input bit aggressive, input int max_cyc);
    int n = 0;
    int r;
    while (m_mode != 3 && n < max_cyc) begin
      r = $urandom_range(0, 9);
      if (m_mode == 2) begin
        if (aggressive) bus.btn = (bus.btn == '0) ? 4'(1 << m_lit) : '0;
        else if (r < 4) bus.btn = 4'(1 << m_lit);
        else if (r == 4) bus.btn = 4'((1 << m_lit) | (1 << ((m_lit + 1 + $urandom_range(0, 2)) % NM)));
        else if (r == 5) bus.btn = 4'(1 << ((m_lit + 1 + $urandom_range(0, 2)) % NM));
        else if (r < 8) bus.btn = '0;
      end else begin
        bus.btn = (r < 3) ? 4'($urandom_range(0, 15)) : '0;
      end
      // Stray start presses mid-round must be ignored; keep them clear of the round end.
      bus.start = (m_cyc - m_rs < ROUND * TICK - 5) && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      n++;
    end
    check("round_end", m_mode, 3);
    bus.btn   = '0;
    bus.start = 1'b0;
  endtask

  int lit;

  initial begin
    bus.start = 1'b0;
    bus.btn   = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_secs", bus.secs_left, ROUND);
    check("idle_score", bus.score, 0);
    check("idle_leds", bus.mole_leds, 0);
    check("idle_playing", bus.playing, 0);
    check("idle_game_over", bus.game_over, 0);

    // Round 1: first mole, a clean hit, then let the round run out.
    pulse_start();
    @(negedge clk);
    check("start_playing", bus.playing, 1);
    repeat (2) @(negedge clk);
    check("first_mole", bus.mole_leds, 1 << m_lit);
    check("first_mole_onehot", $countones(bus.mole_leds), 1);
    lit = m_lit;
    bus.btn = 4'(1 << lit);
    @(negedge clk);
    bus.btn = '0;
    @(negedge clk);
    check("hit_score", bus.score, 1);
    check("hit_leds_off", bus.mole_leds, 0);
    repeat (2) @(negedge clk);
    check("next_mole_onehot", $countones(bus.mole_leds), 1);
    wait_mode(3, 100);
    check("done_score_held", bus.score, 1);
    check("done_secs", bus.secs_left, 0);
    check("done_leds", bus.mole_leds, 0);
    check("done_flag", bus.game_over, 1);

    // Round 2: no presses, watch the seconds countdown.
    pulse_start();
    wait_mode(1, 10);
    check("restart_score", bus.score, 0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 9 || i == 10 || i == 19 || i == 20 || i == 29)
        check($sformatf("secs_at_%0d", i), bus.secs_left, ROUND - i / 10);
    end
    check("timeout_game_over", bus.game_over, 1);
    check("timeout_secs", bus.secs_left, 0);
    check("timeout_leds", bus.mole_leds, 0);
    check("timeout_playing", bus.playing, 0);

    // Round 3: mashed and wrong presses are ignored; mole times out.
    pulse_start();
    wait_mode(2, 20);
    lit = m_lit;
    bus.btn = 4'((1 << lit) | (1 << ((lit + 1) % NM)));
    @(negedge clk);
    bus.btn = '0;
    @(negedge clk);
    bus.btn = 4'(1 << ((lit + 2) % NM));
    @(negedge clk);
    bus.btn = '0;
    repeat (2) @(negedge clk);
    check("mash_still_lit", bus.mole_leds, 1 << lit);
    check("mash_score", bus.score, 0);
    @(negedge clk);
    check("mash_timeout_off", bus.mole_leds, 0);
    check("mash_playing", bus.playing, 1);
    wait_mode(3, 100);

    // Round 4: hit lands on the same cycle as the final tick.
    pulse_start();
    wait_mode(1, 10);
    repeat (28) @(negedge clk);
    bus.btn = 4'(1 << m_lit);
    @(negedge clk);
    bus.btn = '0;
    @(negedge clk);
    check("final_tick_score", bus.score, 1);
    check("final_tick_done", bus.game_over, 1);
    check("final_tick_leds", bus.mole_leds, 0);

    for (int r = 0; r < 6; r++) begin
      pulse_start();
      wait_mode(1, 10);
      play_random(r == 2 || r == 5, 200);
      check("rand_score", bus.score, m_score);
    end

    // Asynchronous reset while a mole is up.
    pulse_start();
    wait_mode(2, 20);
    bus.btn = 4'(1 << m_lit);
    @(negedge clk);
    bus.btn = '0;
    wait_mode(1, 10);
    wait_mode(2, 20);
    check("pre_reset_score", bus.score, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_leds", bus.mole_leds, 0);
    check("rst_score", bus.score, 0);
    check("rst_secs", bus.secs_left, ROUND);
    check("rst_playing", bus.playing, 0);
    check("rst_game_over", bus.game_over, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", bus.playing, 0);
    check("post_rst_secs", bus.secs_left, ROUND);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/whack_mole_round_ctrl.md
# whack_mole_round_ctrl

Round controller for the whack-a-mole game. Owns the 20-second round countdown and sequences mole LEDs. Turns button presses into a score and drives the seconds-left and game-over outputs for the display logic. Sits between the debounced push-buttons and the seven-segment/LED drivers, and replaces free-running timer control with a single sequenced round.

## Interface
- CLK_HZ, 100_000_000: board clock frequency; one second = CLK_HZ cycles (TICK_CYCLES = CLK_HZ).
- ROUND_SECS, 20: round length in seconds; fits in 5 bits.
- NUM_MOLES, 4: mole/button count; power of two, 2..8.
- MOLE_CYCLES, 75_000_000: cycles a mole stays lit.
- GAP_CYCLES, 25_000_000: cycles between moles.
- SCORE_W, 8: score width.
- clk  in  1  board clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  debounced start button, level; rising edge sampled.
- btn  in  NUM_MOLES  debounced, synchronous mole buttons, level.
- mole_leds  out  NUM_MOLES  one-hot lit mole, or all zero.
- score  out  SCORE_W  hits this round, saturating.
- secs_left  out  5  seconds remaining.
- playing  out  1  high in SPAWN_WAIT/MOLE_UP.
- game_over  out  1  high in DONE.

## Operation
- Edge detect: registered copies start_q and btn_q; start_rise = start & ~start_q; btn_rise = btn & ~btn_q. Cleared by reset.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advances every cycle, never all-zero.
- States: IDLE, SPAWN_WAIT, MOLE_UP, DONE.
- IDLE/DONE + start_rise:
  - score <= 0, secs_left <= ROUND_SECS, prescaler <= 0, gap counter <= GAP_CYCLES-1.
  - Go to SPAWN_WAIT.
- SPAWN_WAIT: gap counter decrements. At 0, lit index <= LFSR[log2(NUM_MOLES)-1:0], mole counter <= MOLE_CYCLES-1, go to MOLE_UP.
- MOLE_UP: mole_leds = one-hot(lit index).
  - Hit: btn_rise has exactly the lit bit set and no other bits. Hit gives score+1 (saturates at all-ones), gap counter reload, go to SPAWN_WAIT.
  - Any btn_rise with a non-lit bit set is not a hit (anti-mash): ignored, mole stays lit.
  - Mole counter at 0 with no hit: go to SPAWN_WAIT, gap reload, no score change.
- Round timer, active in SPAWN_WAIT and MOLE_UP only:
  - Prescaler counts 0..TICK_CYCLES-1; on wrap, secs_left decrements.
  - A wrap that takes secs_left from 1 to 0 forces DONE next cycle. This has priority over spawn and timeout transitions.
- Simultaneous hit and final tick: the hit is scored, then DONE.
- start_rise while playing is ignored.
- DONE: mole_leds = 0, score and secs_left (=0) held until the next start_rise.

## Timing
- Reset values: state IDLE, mole_leds 0, score 0, secs_left ROUND_SECS, playing 0, game_over 0, LFSR 8'hA5.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- start/btn rises at input in cycle N are seen as edges in cycle N+1; state, score and LEDs update in cycle N+2.
- First mole lights GAP_CYCLES cycles after SPAWN_WAIT entry.
- A mole is lit for exactly MOLE_CYCLES cycles unless hit.
- Seconds: first decrement TICK_CYCLES cycles after SPAWN_WAIT entry. Round lasts ROUND_SECS×TICK_CYCLES cycles, then DONE.
- Reset asserted mid-round: immediate asynchronous return to reset values. After deassert, a new start_rise is required.
- Button held across round start produces no hit; only a fresh rise counts.

## Structure
- Package whack_mole_pkg:
  - state enum (IDLE, SPAWN_WAIT, MOLE_UP, DONE).
  - LFSR_SEED = 8'hA5 and the LFSR tap mask.
  - Default ROUND_SECS.
- Sub-module round_timer:
  - Holds the prescaler and the 5-bit seconds down-counter.
  - Inputs: clk, reset_n, load, run.
  - Outputs: secs_left and a one-cycle expire pulse on the 1→0 transition.
- Controller FSM, LFSR, edge detectors, mole/gap counter and score live in the top module.

## Test plan
Bench parameters: TICK_CYCLES=10, ROUND_SECS=3, MOLE_CYCLES=6, GAP_CYCLES=2, NUM_MOLES=4.
- Reset, then idle 50 cycles -> secs_left=3, score=0, mole_leds=0, playing=0, game_over=0.
- start pulse -> playing high 2 cycles later; mole_leds one-hot after a further 2 cycles; lit index matches the LFSR model.
- Press the lit button during MOLE_UP -> score=1 two cycles after the rise, mole_leds=0, next mole 2 cycles later.
- Press the lit and a non-lit button together, then a wrong button alone -> score unchanged, mole stays lit until the 6-cycle timeout.
- No presses for the whole round -> secs_left 3→2→1→0 every 10 cycles, game_over=1 30 cycles after round start, mole_leds=0. start restarts with score=0.
- Hit on the same cycle as the final tick -> score increments and DONE. Assert reset_n low mid-MOLE_UP -> all outputs return to reset values immediately.
